// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Multicycle control sequencer for the MIPS execute datapath.
//               Steps each instruction through FETCH, DECODE, EXECUTE, MEM
//               and WB. It produces one-cycle write enables for the
//               instruction register, PC, register file and data memory.
//               It waits on the data-memory ready handshake with a bounded
//               timeout, and it can count retired instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_WAIT_MAX : MEM wait cycles without mem_ready before ERROR (1..255)
// Build option:
//   EXEC_SEQ_STATS_EN : when defined, instr_count is a live retire counter;
//                       otherwise instr_count is tied to zero.
// Ports:
//   CLK         in   1  system clock, rising edge
//   RST         in   1  asynchronous active-high reset
//   start       in   1  leave IDLE and begin fetching
//   instr       in  32  instruction-register contents
//   zero        in   1  ALU zero flag (valid in EXECUTE)
//   mem_ready   in   1  data-memory access complete
//   ir_write    out  1  load instruction register
//   pc_write    out  1  update PC
//   pc_src      out  2  00 = pc+4, 01 = branch target, 10 = jump target
//   reg_write   out  1  register-file write enable
//   mem_read    out  1  data-memory read request
//   mem_write   out  1  data-memory write request
//   busy        out  1  high outside IDLE and ERROR
//   mem_timeout out  1  sticky memory-timeout flag
//   state       out  3  current state encoding
//   instr_count out 32  retired-instruction count
// ============================================================================
module exec_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        busy,
  output logic        mem_timeout,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam logic [7:0] c_WAIT_MAX  = 8'(MEM_WAIT_MAX);
  localparam logic [1:0] c_SRC_PC4   = 2'b00;
  localparam logic [1:0] c_SRC_BRCH  = 2'b01;
  localparam logic [1:0] c_SRC_JUMP  = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;

  // --------------------------------------------------------------------------
  // Opcode classification
  // --------------------------------------------------------------------------
  logic [5:0] w_op;
  logic       w_is_halt;
  logic       w_is_rtype;
  logic       w_is_alui;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_j;

  assign w_op       = instr[31:26];
  assign w_is_halt  = (instr == 32'hFFFF_FFFF);
  assign w_is_rtype = (w_op == 6'h00);
  assign w_is_alui  = (w_op == 6'h08) || (w_op == 6'h09) || (w_op == 6'h0A) ||
                      (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0F);
  assign w_is_lw    = (w_op == 6'h23);
  assign w_is_sw    = (w_op == 6'h2B);
  assign w_is_beq   = (w_op == 6'h04);
  assign w_is_bne   = (w_op == 6'h05);
  assign w_is_j     = (w_op == 6'h02);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // MEM wait counter. Held at zero outside MEM so it starts from zero on
  // every MEM entry; counts only cycles in which memory has not answered.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state != S_MEM) begin
      r_wait_cnt <= 8'd0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and enable decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = c_SRC_PC4;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_write     = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        if (w_is_halt) begin
          w_next_state = S_IDLE;
        end else if (w_is_j) begin
          pc_write     = 1'b1;
          pc_src       = c_SRC_JUMP;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        if (w_is_beq) begin
          pc_write     = 1'b1;
          pc_src       = zero ? c_SRC_BRCH : c_SRC_PC4;
          w_next_state = S_FETCH;
        end else if (w_is_bne) begin
          pc_write     = 1'b1;
          pc_src       = zero ? c_SRC_PC4 : c_SRC_BRCH;
          w_next_state = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = S_MEM;
        end else if (w_is_rtype || w_is_alui) begin
          w_next_state = S_WB;
        end else begin
          // Unknown opcode: advance the PC and retire as a NOP.
          pc_write     = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      S_MEM: begin
        mem_read  = w_is_lw;
        mem_write = w_is_sw;
        // mem_ready takes priority over the timeout check in the same cycle.
        if (mem_ready) begin
          if (w_is_lw) begin
            w_next_state = S_WB;
          end else begin
            // Any non-load access completes here like a store.
            pc_write     = 1'b1;
            w_next_state = S_FETCH;
          end
        end else if (r_wait_cnt == c_WAIT_MAX) begin
          w_next_state = S_ERROR;
        end
      end

      S_WB: begin
        reg_write    = 1'b1;
        pc_write     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_ERROR: begin
        w_next_state = S_ERROR;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_ERROR);
  // ERROR is only left through reset, so decoding it from state is sticky.
  assign mem_timeout = (r_state == S_ERROR);
  assign state       = r_state;

  // --------------------------------------------------------------------------
  // Retired-instruction counter
  // --------------------------------------------------------------------------
`ifdef EXEC_SEQ_STATS_EN
  logic        w_retire;
  logic [31:0] r_instr_count;

  // Every retiring cycle updates the PC and every PC update retires an
  // instruction, so pc_write doubles as the retire strobe.
  assign w_retire = pc_write;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr_count <= 32'd0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Self-checking bench for exec_sequencer. A table of per-cycle
//               vectors walks every instruction class; hand-written sequences
//               cover the MEM timeout boundary, ERROR stickiness and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  localparam logic [31:0] I_ADD  = 32'h0000_0020;
  localparam logic [31:0] I_LW   = 32'h8C00_0004;
  localparam logic [31:0] I_BEQ  = 32'h1000_0003;
  localparam logic [31:0] I_BNE  = 32'h1400_0000;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_UNK  = 32'hFC00_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_ADDI = 32'h2001_0005;
  localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write;
  logic        busy, mem_timeout;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  exec_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .CLK(CLK), .RST(RST), .start(start), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .busy(busy), .mem_timeout(mem_timeout),
    .state(state), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        start;
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        busy;
    logic        to;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic [31:0] ins,
                              input logic z, input logic r,
                              input logic [2:0] st, input logic irw,
                              input logic pcw, input logic [1:0] src,
                              input logic rw, input logic mr, input logic mw,
                              input logic bsy, input logic to,
                              input logic [31:0] cnt);
    vec_t v;
    v.start = s;   v.instr = ins; v.zero = z;  v.rdy = r;
    v.st = st;     v.irw = irw;   v.pcw = pcw; v.src = src;
    v.rw = rw;     v.mr = mr;     v.mw = mw;   v.busy = bsy;
    v.to = to;     v.cnt = cnt;
    return v;
  endfunction

  // Expected counter value depends on whether the stats build is enabled.
  function automatic logic [31:0] ecnt(input logic [31:0] c);
`ifdef EXEC_SEQ_STATS_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  function automatic logic [11:0] pack_exp(input vec_t v);
    return {v.st, v.irw, v.pcw, v.src, v.rw, v.mr, v.mw, v.busy, v.to};
  endfunction

  function automatic logic [11:0] pack_act();
    return {state, ir_write, pc_write, pc_src, reg_write, mem_read,
            mem_write, busy, mem_timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and let the
  // combinational outputs settle before any checks.
  task automatic step(input logic s, input logic [31:0] ins,
                      input logic z, input logic r);
    @(negedge CLK);
    start = s; instr = ins; zero = z; mem_ready = r;
    #1;
  endtask

  initial begin
    // Vector columns: start instr zero rdy | st irw pcw src rw mr mw busy to cnt
    vq.push_back(mk(0, I_ADD,  0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, I_ADD,  0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, I_ADD,  0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, I_ADD,  0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, I_ADD,  0, 0, 3'd3, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, I_ADD,  0, 0, 3'd5, 0, 1, 2'b00, 1, 0, 0, 1, 0, 0));
    // lw with mem_ready on the third MEM cycle
    vq.push_back(mk(0, I_LW,   0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 0, 3'd3, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 0, 3'd4, 0, 0, 2'b00, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 0, 3'd4, 0, 0, 2'b00, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 1, 3'd4, 0, 0, 2'b00, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, I_LW,   0, 0, 3'd5, 0, 1, 2'b00, 1, 0, 0, 1, 0, 1));
    // beq taken, then not taken
    vq.push_back(mk(0, I_BEQ,  0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 2));
    vq.push_back(mk(0, I_BEQ,  0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 2));
    vq.push_back(mk(0, I_BEQ,  1, 0, 3'd3, 0, 1, 2'b01, 0, 0, 0, 1, 0, 2));
    vq.push_back(mk(0, I_BEQ,  0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, I_BEQ,  0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, I_BEQ,  0, 0, 3'd3, 0, 1, 2'b00, 0, 0, 0, 1, 0, 3));
    // jump retires from DECODE
    vq.push_back(mk(0, I_J,    0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 4));
    vq.push_back(mk(0, I_J,    0, 0, 3'd2, 0, 1, 2'b10, 0, 0, 0, 1, 0, 4));
    // bne with zero=1 (not taken), then zero=0 (taken)
    vq.push_back(mk(0, I_BNE,  1, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 5));
    vq.push_back(mk(0, I_BNE,  1, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 5));
    vq.push_back(mk(0, I_BNE,  1, 0, 3'd3, 0, 1, 2'b00, 0, 0, 0, 1, 0, 5));
    vq.push_back(mk(0, I_BNE,  0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 6));
    vq.push_back(mk(0, I_BNE,  0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 6));
    vq.push_back(mk(0, I_BNE,  0, 0, 3'd3, 0, 1, 2'b01, 0, 0, 0, 1, 0, 6));
    // unknown opcode executes as a NOP
    vq.push_back(mk(0, I_UNK,  0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 7));
    vq.push_back(mk(0, I_UNK,  0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 7));
    vq.push_back(mk(0, I_UNK,  0, 0, 3'd3, 0, 1, 2'b00, 0, 0, 0, 1, 0, 7));
    // sw with zero wait cycles
    vq.push_back(mk(0, I_SW,   0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 8));
    vq.push_back(mk(0, I_SW,   0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 8));
    vq.push_back(mk(0, I_SW,   0, 0, 3'd3, 0, 0, 2'b00, 0, 0, 0, 1, 0, 8));
    vq.push_back(mk(0, I_SW,   0, 1, 3'd4, 0, 1, 2'b00, 0, 0, 1, 1, 0, 8));
    // ALU-immediate
    vq.push_back(mk(0, I_ADDI, 0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 9));
    vq.push_back(mk(0, I_ADDI, 0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 9));
    vq.push_back(mk(0, I_ADDI, 0, 0, 3'd3, 0, 0, 2'b00, 0, 0, 0, 1, 0, 9));
    vq.push_back(mk(0, I_ADDI, 0, 0, 3'd5, 0, 1, 2'b00, 1, 0, 0, 1, 0, 9));
    // HALT returns to IDLE without retiring
    vq.push_back(mk(0, I_HALT, 0, 0, 3'd1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 10));
    vq.push_back(mk(0, I_HALT, 0, 0, 3'd2, 0, 0, 2'b00, 0, 0, 0, 1, 0, 10));
    vq.push_back(mk(0, I_HALT, 0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 10));

    // ---------------- reset state ----------------
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("reset outs", 32'(pack_act()), 32'h0);
    check("reset cnt", instr_count, 32'h0);
    RST = 1'b0;

    // ---------------- table-driven vectors ----------------
    foreach (vq[i]) begin
      step(vq[i].start, vq[i].instr, vq[i].zero, vq[i].rdy);
      check($sformatf("vec%0d outs", i), 32'(pack_act()), 32'(pack_exp(vq[i])));
      check($sformatf("vec%0d cnt", i), instr_count, ecnt(vq[i].cnt));
    end

    // ---------------- mem_ready at the timeout boundary wins ----------------
    step(1, I_SW, 0, 0);
    check("bnd idle", 32'(state), 32'd0);
    step(0, I_SW, 0, 0);
    step(0, I_SW, 0, 0);
    step(0, I_SW, 0, 0);
    check("bnd exec", 32'(state), 32'd3);
    for (int i = 0; i < 15; i++) begin
      step(0, I_SW, 0, 0);
      check($sformatf("bnd mem%0d", i), 32'({state, mem_write, pc_write}), 32'({3'd4, 1'b1, 1'b0}));
    end
    step(0, I_SW, 0, 1);
    check("bnd ready", 32'({state, mem_write, pc_write}), 32'({3'd4, 1'b1, 1'b1}));
    step(0, I_HALT, 0, 0);
    check("bnd fetch", 32'({state, mem_timeout}), 32'({3'd1, 1'b0}));
    step(0, I_HALT, 0, 0);
    step(0, I_HALT, 0, 0);
    check("bnd halt", 32'({state, busy}), 32'({3'd0, 1'b0}));
    check("bnd cnt", instr_count, ecnt(32'd11));

    // ---------------- sw timeout into sticky ERROR ----------------
    step(1, I_SW, 0, 0);
    step(0, I_SW, 0, 0);
    step(0, I_SW, 0, 0);
    step(0, I_SW, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, I_SW, 0, 0);
      check($sformatf("to mem%0d", i), 32'({state, mem_write, mem_timeout}), 32'({3'd4, 1'b1, 1'b0}));
    end
    step(1, I_SW, 0, 1);
    check("to error", 32'(pack_act()), 32'({3'd6, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    step(1, I_LW, 1, 1);
    check("to sticky", 32'(pack_act()), 32'({3'd6, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("to cnt", instr_count, ecnt(32'd11));
    RST = 1'b1;
    #1;
    check("to rst", 32'({state, mem_timeout}), 32'({3'd0, 1'b0}));
    check("to rst cnt", instr_count, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // ---------------- async reset in MEM mid-lw ----------------
    step(1, I_LW, 0, 0);
    step(0, I_LW, 0, 0);
    step(0, I_LW, 0, 0);
    step(0, I_LW, 0, 0);
    step(0, I_LW, 0, 0);
    check("lwrst mem", 32'({state, mem_read}), 32'({3'd4, 1'b1}));
    RST = 1'b1;
    #1;
    check("lwrst async", 32'(pack_act()), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    step(0, I_LW, 0, 1);
    check("lwrst idle", 32'({state, busy}), 32'({3'd0, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
# exec_sequencer

Multicycle control sequencer for the MIPS execute datapath: walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB states. It emits one-cycle write enables for the instruction register, PC, register file and data memory, so the datapath no longer retires every instruction in a single clock. It also waits on a data-memory ready handshake with a timeout, and counts retired instructions. It sits between fetch and execute_unit and replaces the static enables that decode_instr drives today.

## Interface
Parameters:
- MEM_WAIT_MAX, default 15: maximum MEM-state wait cycles without mem_ready before ERROR (range 1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  leave IDLE and begin fetching.
- instr  in  32  current instruction-register contents.
- zero  in  1  ALU zero flag, same cycle as EXECUTE.
- mem_ready  in  1  data-memory access complete.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00 = pc+4, 01 = branch target, 10 = jump target.
- reg_write  out  1  register-file write enable.
- mem_read  out  1  data-memory read request.
- mem_write  out  1  data-memory write request.
- busy  out  1  high in every state except IDLE and ERROR.
- mem_timeout  out  1  sticky error flag.
- state  out  3  current state encoding.
- instr_count  out  32  retired-instruction count.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, ERROR=6. State is registered.
- All enables, including pc_src, are combinational from the state register, instr, zero and mem_ready. Every enable is 0 unless listed below.
- Opcode classes, from instr[31:26]:
  - R-type: 0x00.
  - ALU-imm: 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0F.
  - lw: 0x23.
  - sw: 0x2B.
  - beq: 0x04.
  - bne: 0x05.
  - j: 0x02.
  - HALT: instr == 0xFFFF_FFFF.
  - Anything else is unknown.
- IDLE: if start, go to FETCH. Otherwise stay.
- FETCH: ir_write=1, then go to DECODE.
- DECODE:
  - HALT: go to IDLE, not retired.
  - j: pc_write=1, pc_src=10, retire, go to FETCH.
  - All other classes: go to EXECUTE.
- EXECUTE:
  - beq: pc_write=1; pc_src=01 if zero, else 00; retire; go to FETCH.
  - bne: same as beq with the zero condition inverted.
  - lw or sw: go to MEM.
  - R-type or ALU-imm: go to WB.
  - Unknown: pc_write=1, pc_src=00, retire, go to FETCH (executes as a NOP).
- MEM:
  - mem_read=1 for lw, mem_write=1 for sw, held every MEM cycle until mem_ready.
  - On mem_ready with lw: go to WB.
  - On mem_ready with sw: pc_write=1, pc_src=00, retire, go to FETCH.
  - An 8-bit wait counter clears on MEM entry and increments on each MEM cycle without mem_ready.
  - When the counter equals MEM_WAIT_MAX and mem_ready is low: go to ERROR.
  - mem_ready wins if it arrives in the same cycle the counter equals MEM_WAIT_MAX.
- WB: reg_write=1, pc_write=1, pc_src=00, retire, go to FETCH.
- ERROR: mem_timeout=1, all enables 0. Leaves only on RST.
- Retire: instr_count increments by 1 and wraps from 0xFFFF_FFFF to 0.
- start is ignored outside IDLE.

## Timing
- RST, any cycle including mid-instruction, asynchronously forces:
  - state = IDLE (0), wait counter = 0, instr_count = 0, mem_timeout = 0.
  - All enables and busy = 0, pc_src = 00.
- Cycles per instruction, FETCH through retire:
  - j: 2.
  - beq/bne/unknown: 3.
  - R-type/ALU-imm: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.
- Wait cycles = MEM cycles before the mem_ready cycle. Zero wait cycles means mem_ready is high on the first MEM cycle.
- Timeout is reached after MEM_WAIT_MAX+1 consecutive MEM cycles with mem_ready low. ERROR is entered on the following edge.
- instr_count updates on the clock edge that leaves the retiring state.

## Configuration
- EXEC_SEQ_STATS_EN defined: instr_count register present and behaves as above.
- Not defined: no counter register; instr_count is tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset then start with instr=0x0000_0020 (add), hold: states 1→2→3→5→1. reg_write and pc_write pulse together in WB, pc_src=00, instr_count=1.
- lw 0x8C00_0004 with mem_ready asserted on the 3rd MEM cycle: mem_read high for 3 cycles, then WB with reg_write=1; 7 cycles total.
- beq 0x1000_0003 with zero=1: pc_write=1, pc_src=01 in EXECUTE. Same instruction with zero=0: pc_src=00.
- sw 0xAC00_0000 with mem_ready never asserted and MEM_WAIT_MAX=15: 16 MEM cycles, then state=6 and mem_timeout=1 stuck. RST clears both.
- j 0x0800_0010, then instr=0xFFFF_FFFF: jump retires in 2 cycles with pc_src=10, then HALT returns to IDLE with instr_count=1 and busy=0.
- Assert RST in MEM mid-lw: state=0 and mem_read=0 immediately, before the next CLK edge.
